// File: rtl/gpu_sched_pkg.sv
// Shared constants for the primitive scheduler: screen geometry, the
// no-pixel sentinel, FSM state codes and engine op codes.
package gpu_sched_pkg;

  localparam int WIDTH_BITS   = 10;
  localparam int HEIGHT_BITS  = 9;
  localparam int CHANNEL_BITS = 8;

  // Screen size doubles as the "no pixel" sentinel driven by idle engines.
  localparam logic [WIDTH_BITS-1:0]  SCREEN_W = 10'd640;
  localparam logic [HEIGHT_BITS-1:0] SCREEN_H = 9'd480;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  localparam logic [1:0] OP_FILL_CIRCLE = 2'd0;
  localparam logic [1:0] OP_LINE        = 2'd1;
  localparam logic [1:0] OP_FILL_RECT   = 2'd2;

  // Unsigned compare: coordinates that wrapped below zero land far above
  // the screen size and are rejected here.
  function automatic logic pix_on_screen(input logic [WIDTH_BITS-1:0]  x,
                                         input logic [HEIGHT_BITS-1:0] y);
    return (x < SCREEN_W) && (y < SCREEN_H);
  endfunction

endpackage

// File: rtl/gpu_pixel_filter.sv
// Cleans the selected engine's X/Y stream: drops sentinel and off-screen
// coordinates and repeats of the last emitted pixel, then registers the result.
module gpu_pixel_filter
  import gpu_sched_pkg::*;
(
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   clear,
  input  logic                   en,
  input  logic [WIDTH_BITS-1:0]  x,
  input  logic [HEIGHT_BITS-1:0] y,
  output logic                   pix_valid,
  output logic [WIDTH_BITS-1:0]  pix_x,
  output logic [HEIGHT_BITS-1:0] pix_y
);

  logic                   valid_q, valid_d;
  logic [WIDTH_BITS-1:0]  x_q, x_d, last_x_q, last_x_d;
  logic [HEIGHT_BITS-1:0] y_q, y_d, last_y_q, last_y_d;
  logic                   dup;

  // Accept/reject the incoming coordinate and track the last emitted pixel.
  always_comb begin
    dup      = (x == last_x_q) && (y == last_y_q);
    valid_d  = en && pix_on_screen(x, y) && !dup;
    x_d      = en ? x : x_q;
    y_d      = en ? y : y_q;
    last_x_d = last_x_q;
    last_y_d = last_y_q;
    if (clear) begin
      last_x_d = SCREEN_W;
      last_y_d = SCREEN_H;
    end else if (valid_d) begin
      last_x_d = x;
      last_y_d = y;
    end
  end

  // Output and dedupe registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      valid_q  <= 1'b0;
      x_q      <= SCREEN_W;
      y_q      <= SCREEN_H;
      last_x_q <= SCREEN_W;
      last_y_q <= SCREEN_H;
    end else begin
      valid_q  <= valid_d;
      x_q      <= x_d;
      y_q      <= y_d;
      last_x_q <= last_x_d;
      last_y_q <= last_y_d;
    end
  end

  assign pix_valid = valid_q;
  assign pix_x     = x_q;
  assign pix_y     = y_q;

endmodule

// File: rtl/gpu_prim_scheduler.sv
// Dispatches drawing commands to one primitive engine at a time, holds the
// engine's level start until done (or watchdog expiry), and forwards the
// filtered pixel stream with the command colour.
//
//   state    | meaning
//   ST_IDLE  | ready for a command
//   ST_RUN   | start held high on the selected engine, watchdog counting
//   ST_GAP   | one cycle with every start low so engines re-arm; done pulses
//   ST_ERR   | bad op code: flag error, pulse done, no start issued
module gpu_prim_scheduler
  import gpu_sched_pkg::*;
#(
  parameter int                 NUM_ENG = 3,
  parameter int                 TO_BITS = 20,
  parameter logic [TO_BITS-1:0] TIMEOUT = 20'hFFFFF
) (
  input  logic                            clk,
  input  logic                            n_rst,
  input  logic                            cmd_valid_i,
  output logic                            cmd_ready_o,
  input  logic [1:0]                      cmd_op_i,
  input  logic [CHANNEL_BITS-1:0]         cmd_r_i,
  input  logic [CHANNEL_BITS-1:0]         cmd_g_i,
  input  logic [CHANNEL_BITS-1:0]         cmd_b_i,
  output logic [NUM_ENG-1:0]              eng_start_o,
  input  logic [NUM_ENG-1:0]              eng_done_i,
  input  logic [NUM_ENG*WIDTH_BITS-1:0]   eng_x_i,
  input  logic [NUM_ENG*HEIGHT_BITS-1:0]  eng_y_i,
  output logic                            pix_valid_o,
  output logic [WIDTH_BITS-1:0]           pix_x_o,
  output logic [HEIGHT_BITS-1:0]          pix_y_o,
  output logic [CHANNEL_BITS-1:0]         pix_r_o,
  output logic [CHANNEL_BITS-1:0]         pix_g_o,
  output logic [CHANNEL_BITS-1:0]         pix_b_o,
  output logic                            cmd_done_o,
  output logic                            err_o,
  input  logic                            err_clr_i
);

  localparam logic [2:0] NUM_ENG_W = 3'(NUM_ENG);

  logic [1:0]              state_q, state_d;
  logic [1:0]              op_q, op_d;
  logic [CHANNEL_BITS-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic [TO_BITS-1:0]      wd_q, wd_d, wd_inc;
  logic                    err_q, err_d, err_set;
  logic                    accept, op_ok, done_sel;
  logic [WIDTH_BITS-1:0]   sel_x;
  logic [HEIGHT_BITS-1:0]  sel_y;

  assign cmd_ready_o = (state_q == ST_IDLE);
  assign accept      = cmd_valid_i && cmd_ready_o;
  assign op_ok       = ({1'b0, cmd_op_i} < NUM_ENG_W);
  assign wd_inc      = (wd_q == TIMEOUT) ? wd_q : wd_q + TO_BITS'(1);

  // Select the active engine's coordinates and done, and drive its start.
  always_comb begin
    sel_x       = SCREEN_W;
    sel_y       = SCREEN_H;
    done_sel    = 1'b0;
    eng_start_o = '0;
    for (int i = 0; i < NUM_ENG; i++) begin
      if (op_q == 2'(i)) begin
        sel_x          = eng_x_i[i*WIDTH_BITS +: WIDTH_BITS];
        sel_y          = eng_y_i[i*HEIGHT_BITS +: HEIGHT_BITS];
        done_sel       = eng_done_i[i];
        eng_start_o[i] = (state_q == ST_RUN);
      end
    end
  end

  // Command FSM, watchdog, colour latch and sticky error (set beats clear).
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    r_d     = r_q;
    g_d     = g_q;
    b_d     = b_q;
    wd_d    = wd_q;
    err_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          op_d    = cmd_op_i;
          r_d     = cmd_r_i;
          g_d     = cmd_g_i;
          b_d     = cmd_b_i;
          wd_d    = '0;
          state_d = op_ok ? ST_RUN : ST_ERR;
          err_set = !op_ok;
        end
      end
      ST_RUN: begin
        wd_d = wd_inc;
        if (done_sel) begin
          state_d = ST_GAP;
        end else if (wd_inc == TIMEOUT) begin
          state_d = ST_GAP;
          err_set = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    err_d = err_set || (err_q && !err_clr_i);
  end

  // Control state registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
    end
  end

  gpu_pixel_filter u_filter (
    .clk       (clk),
    .n_rst     (n_rst),
    .clear     (accept),
    .en        (state_q == ST_RUN),
    .x         (sel_x),
    .y         (sel_y),
    .pix_valid (pix_valid_o),
    .pix_x     (pix_x_o),
    .pix_y     (pix_y_o)
  );

  assign cmd_done_o = (state_q == ST_GAP) || (state_q == ST_ERR);
  assign err_o      = err_q;
  assign pix_r_o    = r_q;
  assign pix_g_o    = g_q;
  assign pix_b_o    = b_q;

endmodule
